// File: rtl/axis_audio_arbiter.sv
// Frame-aligned AXI-Stream arbiter/mixer feeding the I2S2 transmit stream.
// Source 0 (line-in) and source 1 (CPU/song) share the TX path. The owner is
// chosen only between stereo frames, so left/right never swap. Mix mode sums
// both sources with saturation.
module axis_audio_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst,
  input  logic [1:0]            mode,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic                  s0_last,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic                  s1_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  err_align
);

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_S0   = 2'b01;
  localparam logic [1:0] G_S1   = 2'b10;
  localparam logic [1:0] G_MIX  = 2'b11;

  logic [1:0]                   state;
  logic                         can_load;
  logic [1:0]                   arb_grant;
  logic                         vld_p0;
  logic signed [DATA_WIDTH-1:0] beat_data_p0;
  logic                         beat_last_p0;
  logic                         last_mismatch_p0;
  logic                         out_last_p0;
  logic                         err_set_p0;

  // Sign-extend by one bit, add, and clamp to the representable range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
      input logic signed [DATA_WIDTH-1:0] a,
      input logic signed [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      sat_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = sum[DATA_WIDTH-1:0];
  endfunction

  assign can_load = !m_valid || m_ready;

  // Source readies: only the owner may move, and a mix beat needs both sides.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    case (grant)
      G_S0:  s0_ready = can_load;
      G_S1:  s1_ready = can_load;
      G_MIX: begin
        s0_ready = can_load && s1_valid;
        s1_ready = can_load && s0_valid;
      end
      default: ;
    endcase
  end

  // Owner selection while between frames.
  always_comb begin
    arb_grant = G_NONE;
    case (mode)
      2'b00: if (s0_valid) arb_grant = G_S0;
      2'b01: if (s1_valid) arb_grant = G_S1;
      2'b10: begin
        if (s1_valid)      arb_grant = G_S1;
        else if (s0_valid) arb_grant = G_S0;
      end
      default: if (s0_valid && s1_valid) arb_grant = G_MIX;
    endcase
  end

  // Beat selection/mixing ahead of the output register.
  always_comb begin
    vld_p0           = 1'b0;
    beat_data_p0     = '0;
    beat_last_p0     = 1'b0;
    last_mismatch_p0 = 1'b0;
    case (grant)
      G_S0: begin
        vld_p0       = s0_valid && can_load;
        beat_data_p0 = s0_data;
        beat_last_p0 = s0_last;
      end
      G_S1: begin
        vld_p0       = s1_valid && can_load;
        beat_data_p0 = s1_data;
        beat_last_p0 = s1_last;
      end
      G_MIX: begin
        vld_p0           = s0_valid && s1_valid && can_load;
        beat_data_p0     = sat_add($signed(s0_data), $signed(s1_data));
        beat_last_p0     = s0_last;
        last_mismatch_p0 = (s0_last != s1_last);
      end
      default: ;
    endcase
    // The right slot always closes the frame, whatever the source says.
    out_last_p0 = (state == RIGHT) || beat_last_p0;
    err_set_p0  = vld_p0 && (last_mismatch_p0 ||
                             ((state == LEFT)  &&  beat_last_p0) ||
                             ((state == RIGHT) && !beat_last_p0));
  end

  // Frame FSM: arbitrate, then carry one left and one right beat.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state <= ARB;
      grant <= G_NONE;
    end else begin
      case (state)
        ARB: begin
          if (arb_grant != G_NONE) begin
            grant <= arb_grant;
            state <= LEFT;
          end
        end
        LEFT: begin
          if (vld_p0) begin
            if (beat_last_p0) begin
              grant <= G_NONE;
              state <= ARB;
            end else begin
              state <= RIGHT;
            end
          end
        end
        RIGHT: begin
          if (vld_p0) begin
            grant <= G_NONE;
            state <= ARB;
          end
        end
        default: begin
          grant <= G_NONE;
          state <= ARB;
        end
      endcase
    end
  end

  // Completed-frame counter and sticky misalignment flag.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      frame_cnt <= '0;
      err_align <= 1'b0;
    end else begin
      if (vld_p0 && out_last_p0) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      if (err_set_p0)            err_align <= 1'b1;
    end
  end

  // Output register stage (p0 -> m_*).
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (vld_p0) begin
      m_valid <= 1'b1;
      m_data  <= mute ? '0 : beat_data_p0;
      m_last  <= out_last_p0;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/axis_audio_arbiter.md
Name: axis_audio_arbiter

Overview:
- Frame-aligned AXI-Stream arbiter/mixer feeding the I2S2 transmit stream in the axis_clk domain.
- Shares the TX path between source 0 (line-in via the volume controller) and source 1 (CPU/song sample generator).
- Grants either source, by priority, or a saturating mix of both. Grant changes only on stereo-frame boundaries, so L/R never swap.

Parameters:
DATA_WIDTH, 24, sample width (signed two's complement)
CNT_WIDTH, 16, width of the frame counter

Ports:
axis_clk  in  1  audio stream clock
axis_rst  in  1  asynchronous, active-high reset
mode  in  2  00=src0 only, 01=src1 only, 10=src1 priority over src0, 11=mix
mute  in  1  forces output data to 0; handshakes are unchanged
s0_data  in  DATA_WIDTH  source 0 sample
s0_valid  in  1  source 0 valid
s0_ready  out  1  source 0 ready
s0_last  in  1  source 0 right-channel marker
s1_data  in  DATA_WIDTH  source 1 sample
s1_valid  in  1  source 1 valid
s1_ready  out  1  source 1 ready
s1_last  in  1  source 1 right-channel marker
m_data  out  DATA_WIDTH  sample to I2S2 TX
m_valid  out  1  output valid
m_ready  in  1  I2S2 TX ready
m_last  out  1  right-channel marker
grant  out  2  current owner: 00 none, 01 src0, 10 src1, 11 mix
frame_cnt  out  CNT_WIDTH  completed frames (beats with last=1 sent), wraps
err_align  out  1  sticky flag: framing misalignment seen

Behaviour:
Frame and output register
- A frame is two beats: left (last=0), then right (last=1).
- Output is a single register stage (m_data, m_valid, m_last). The stage can load when !m_valid || m_ready.
- A source beat is accepted when the source is granted, valid, and the stage can load. Accept-to-m_valid latency is 1 cycle.
- m_valid falls after m_ready when no new beat loads in that cycle.
- s*_ready is combinational: granted && stage can load, and in mix mode also the other source valid.

FSM states: ARB, LEFT, RIGHT.
ARB (grant=00, both readies 0)
- mode is sampled each cycle. Mid-frame mode changes are ignored until the next ARB.
- 00: grant src0 when s0_valid.
- 01: grant src1 when s1_valid.
- 10: grant src1 if s1_valid, else src0 if s0_valid.
- 11: grant mix only when both valid.
- On grant -> LEFT; no beat is transferred in the ARB cycle.
LEFT
- Accept a beat.
- Accepted beat with last=0 -> RIGHT.
- Accepted beat with last=1 (misaligned): output it with m_last=1, set err_align, increment frame_cnt, -> ARB.
RIGHT
- Accept a beat, output it with m_last=1 regardless of the input last, increment frame_cnt, -> ARB.
- If the input last=0, also set err_align.

Mix arithmetic
- Sign-extend both samples to DATA_WIDTH+1 and add.
- Saturate: sums >2^(DATA_WIDTH-1)-1 clamp to 0x7FFFFF; sums < -2^(DATA_WIDTH-1) clamp to 0x800000 (for the 24-bit default).
- m_last is taken from s0_last. If s0_last != s1_last, set err_align.

Mute
- m_data is loaded with 0. Valid, last, counters and state all behave as if unmuted.

Counters and flags
- frame_cnt wraps from all-ones to 0.
- err_align clears only on reset.
- Non-granted source: ready=0; its stream is held, never dropped.

Reset (asynchronous, any time including mid-frame)
- state=ARB, m_valid=0, m_data=0, m_last=0, grant=00, frame_cnt=0, err_align=0.
- s0_ready=0 and s1_ready=0.
- A partial frame in flight is discarded.

Test Plan:
- Mode 00, src0 streams L=0x000123, R=0x000456, m_ready=1 -> output 0x000123 (last 0), then 0x000456 (last 1); frame_cnt=1; s1_ready stays 0.
- Mode 10, both sources valid; s1 frame granted; s1_valid drops before the next frame -> exactly one s1 frame is sent whole, then src0 is granted at ARB. No L/R interleaving between sources.
- Mode 11, s0=0x700000, s1=0x200000 -> m_data=0x7FFFFF. s0=0x900000, s1=0x900000 -> 0x800000. s0=0x000010, s1=0xFFFFF0 -> 0x000000.
- Backpressure: m_ready held 0 for 5 cycles with m_valid=1 -> m_data/m_last stable, both s*_ready=0. Release -> stream resumes with no loss or duplication.
- Mode switched 00->01 between the left and right beats -> right beat still comes from src0; src1 is granted at the next ARB. Source sends last=1 in the LEFT slot -> err_align=1, frame_cnt increments, FSM returns to ARB.
- Assert axis_rst after a left beat is accepted -> all outputs go to reset values immediately. After release, the next frame starts at LEFT; frame_cnt=0. Counter preset near all-ones wraps to 0.
